// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ==========================================================================
// cpu_mem_pkg : shared types/constants for the fetch/data memory arbiter
// Rev 1.0
// ==========================================================================
package cpu_mem_pkg;

   localparam int ADDR_W_DEFAULT = 10;
   localparam logic [3:0] BE_WORD = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_e;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ==========================================================================
// arb_pick : combinational winner select between fetch and data requests
// Build option ARB_ROUND_ROBIN_EN: alternate on ties. Rev 1.0
// ==========================================================================
module arb_pick
   import cpu_mem_pkg::*;
(
   input  logic    if_req,
   input  logic    d_req,
   input  req_id_e last_grant,
   output logic    pick_valid,
   output req_id_e pick_id
);

   always_comb begin
      pick_valid = if_req | d_req;
      pick_id    = REQ_D;
      if (if_req && !d_req) begin
         pick_id = REQ_IF;
      end else if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         pick_id = (last_grant == REQ_D) ? REQ_IF : REQ_D;
`else
         pick_id = REQ_D;
`endif
      end
   end

`ifndef ARB_ROUND_ROBIN_EN
   // Fixed priority never looks at the previous grant.
   logic unused_last;
   assign unused_last = (last_grant == REQ_D);
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_port_arbiter : shares one single-ported memory between fetch and data
// Build option ARB_ROUND_ROBIN_EN selects round-robin ties. Rev 1.0
// ==========================================================================
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEFAULT,
   parameter int MEM_LAT = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   output logic              if_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   state_e            state_q, state_d;
   req_id_e           owner_q, owner_d, last_q, last_d;
   logic              oob_q, oob_d, wr_q, wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              if_gnt_q, if_gnt_d, if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
   logic              d_gnt_q, d_gnt_d, d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
   logic [31:0]       if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
   logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d, busy_q, busy_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic        pick_valid;
   req_id_e     pick_id;
   logic [31:0] sel_addr;
   logic        sel_oob, sel_wr, rsp_fire;
   logic [31:0] rsp_data;

   arb_pick u_arb_pick (
      .if_req     (if_req),
      .d_req      (d_req),
      .last_grant (last_q),
      .pick_valid (pick_valid),
      .pick_id    (pick_id)
   );

   assign sel_addr = (pick_id == REQ_D) ? d_addr : if_addr;
   assign sel_oob  = |sel_addr[31:ADDR_W+2];
   assign sel_wr   = (pick_id == REQ_D) && d_we;

   // Byte lanes come from d_be only; the low address bits carry no meaning.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      oob_d       = oob_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      if_gnt_d    = 1'b0;
      if_rvalid_d = 1'b0;
      if_rdata_d  = '0;
      if_err_d    = 1'b0;
      d_gnt_d     = 1'b0;
      d_rvalid_d  = 1'b0;
      d_rdata_d   = '0;
      d_err_d     = 1'b0;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_be_d    = '0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_fire    = 1'b0;
      rsp_data    = (oob_q || wr_q) ? 32'h0 : mem_rdata;

      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (pick_valid) begin
               state_d = ST_ISSUE;
               owner_d = pick_id;
               last_d  = pick_id;
               oob_d   = sel_oob;
               wr_d    = sel_wr;
               if (pick_id == REQ_IF) if_gnt_d = 1'b1;
               else                   d_gnt_d  = 1'b1;
               if (!sel_oob) begin
                  mem_en_d    = 1'b1;
                  mem_we_d    = sel_wr;
                  mem_be_d    = sel_wr ? d_be : BE_WORD;
                  mem_addr_d  = sel_addr[ADDR_W+1:2];
                  mem_wdata_d = (pick_id == REQ_D) ? d_wdata : 32'h0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // A rejected address skips WAIT so its error lands one cycle after gnt.
            if (oob_q) begin
               state_d  = ST_RESP;
               rsp_fire = 1'b1;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(MEM_LAT - 1);
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d  = ST_RESP;
               rsp_fire = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (rsp_fire) begin
         if (owner_q == REQ_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = rsp_data;
            if_err_d    = oob_q;
         end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = rsp_data;
            d_err_d    = oob_q;
         end
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= REQ_IF;
         last_q      <= REQ_D;
         oob_q       <= 1'b0;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         if_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         if_err_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         d_rvalid_q  <= 1'b0;
         d_rdata_q   <= '0;
         d_err_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         oob_q       <= oob_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         if_gnt_q    <= if_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         if_err_q    <= if_err_d;
         d_gnt_q     <= d_gnt_d;
         d_rvalid_q  <= d_rvalid_d;
         d_rdata_q   <= d_rdata_d;
         d_err_q     <= d_err_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign d_gnt     = d_gnt_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign d_err     = d_err_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_mem_port_arbiter : directed bench, MEM_LAT=1 and MEM_LAT=3 instances
// Rev 1.0
// ==========================================================================
module tb_mem_port_arbiter;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
   logic [31:0] if_rdata, d_rdata;
   logic        mem_en, mem_we, busy;
   logic [3:0]  mem_be;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;

   logic        b_if_req = 1'b0;
   logic [31:0] b_if_addr = '0;
   logic        b_if_gnt, b_if_rvalid, b_if_err, b_d_gnt, b_d_rvalid, b_d_err;
   logic [31:0] b_if_rdata, b_d_rdata;
   logic        b_mem_en, b_mem_we, b_busy;
   logic [3:0]  b_mem_be;
   logic [9:0]  b_mem_addr;
   logic [31:0] b_mem_wdata;
   logic [31:0] b_pipe0 = '0, b_pipe1 = '0, b_pipe2 = '0;

   mem_port_arbiter #(.ADDR_W(10), .MEM_LAT(1)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(10), .MEM_LAT(3)) u_dut_lat3 (
      .clock(clock), .reset_n(reset_n),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
      .if_rdata(b_if_rdata), .if_err(b_if_err),
      .d_req(1'b0), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h0), .d_wdata(32'h0),
      .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .d_err(b_d_err),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_pipe2), .busy(b_busy)
   );

   // Memory models: 1-cycle read with byte-enabled writes, and a 3-stage read-only one.
   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];

   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem_a[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
         mem_rdata <= mem_a[mem_addr];
      end
   end

   always @(posedge clock) begin
      if (b_mem_en) b_pipe0 <= mem_b[b_mem_addr];
      b_pipe1 <= b_pipe0;
      b_pipe2 <= b_pipe1;
   end

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   int          gk, rk, ng, nrv, busy_bad;
   logic [31:0] rd_seen;
   logic        err_seen, en_seen, cap_we;
   logic [9:0]  cap_addr;
   logic [3:0]  cap_be, order, exp_order;

   // One transaction on the MEM_LAT=1 instance; k counts cycles from the request cycle.
   task automatic run_a(input logic is_d, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
      gk = -1; rk = -1; rd_seen = '0; err_seen = 1'b0; en_seen = 1'b0;
      cap_we = 1'b0; cap_addr = '0; cap_be = '0;
      @(posedge clock); #1;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      for (int k = 0; k < 16; k++) begin
         @(negedge clock);
         if ((is_d ? d_gnt : if_gnt) && gk < 0) begin
            gk = k; if_req = 1'b0; d_req = 1'b0;
         end
         if (is_d ? d_rvalid : if_rvalid) begin
            rk = k;
            rd_seen  = is_d ? d_rdata : if_rdata;
            err_seen = is_d ? d_err : if_err;
         end
         if (mem_en) begin
            en_seen = 1'b1; cap_addr = mem_addr; cap_be = mem_be; cap_we = mem_we;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 32'h0;
         mem_b[i] = 32'h0;
      end
      mem_a[2]  = 32'h2008000A;
      mem_a[16] = 32'h11223344;
      mem_b[2]  = 32'hCAFEF00D;

      repeat (3) @(negedge clock);
      reset_n = 1'b1;

      // Reset asserted while the fetch sits in WAIT
      @(posedge clock); #1;
      if_req = 1'b1; if_addr = 32'h8;
      @(negedge clock);
      @(negedge clock);
      if (if_gnt) if_req = 1'b0;
      @(negedge clock);
      check_eq("rst_busy_before", {31'b0, busy}, 32'h1);
      reset_n = 1'b0;
      #1;
      check_eq("rst_outputs_zero",
               {12'b0, if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err,
                mem_en, mem_we, busy, mem_be, mem_addr}, 32'h0);
      if_req = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      nrv = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (if_rvalid || d_rvalid) nrv++;
      end
      check_eq("rst_no_rvalid", nrv, 0);

      // Simultaneous held requests, four grants
      if_addr = 32'h8; d_addr = 32'h40; d_we = 1'b0; d_be = 4'h0;
      ng = 0; nrv = 0; order = '0;
      @(posedge clock); #1;
      if_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (if_gnt) begin
            if (ng < 4) order[ng] = 1'b0;
            ng++;
         end
         if (d_gnt) begin
            if (ng < 4) order[ng] = 1'b1;
            ng++;
         end
         if (ng >= 4) begin if_req = 1'b0; d_req = 1'b0; end
         if (if_rvalid) nrv++;
         if (d_rvalid) nrv++;
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = 4'b1010;
`else
      exp_order = 4'b1111;
`endif
      check_eq("tie_grant_order", {28'b0, order}, {28'b0, exp_order});
      check_eq("tie_grant_count", ng, 4);
      check_eq("tie_rvalid_count", nrv, 4);

      // Fetch word 2
      run_a(1'b0, 1'b0, 4'h0, 32'h8, 32'h0);
      check_eq("fetch_gnt_cycle", gk, 1);
      check_eq("fetch_rvalid_cycle", rk, 3);
      check_eq("fetch_rdata", rd_seen, 32'h2008000A);
      check_eq("fetch_err", {31'b0, err_seen}, 32'h0);
      check_eq("fetch_mem_be", {28'b0, cap_be}, 32'hF);
      check_eq("fetch_mem_addr", {22'b0, cap_addr}, 32'h2);

      // SB to byte 1 of word 0x10, then LW it back
      run_a(1'b1, 1'b1, 4'b0010, 32'h41, 32'h0000AB00);
      check_eq("sb_gnt_cycle", gk, 1);
      check_eq("sb_rvalid_cycle", rk, 3);
      check_eq("sb_rdata", rd_seen, 32'h0);
      check_eq("sb_mem_addr", {22'b0, cap_addr}, 32'h10);
      check_eq("sb_mem_be", {28'b0, cap_be}, 32'h2);
      check_eq("sb_mem_we", {31'b0, cap_we}, 32'h1);
      run_a(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
      check_eq("lw_rvalid_cycle", rk, 3);
      check_eq("lw_rdata", rd_seen, 32'h1122AB44);
      check_eq("lw_mem_be", {28'b0, cap_be}, 32'hF);

      // Out-of-range data read
      run_a(1'b1, 1'b0, 4'h0, 32'h00001000, 32'h0);
      check_eq("oob_mem_en", {31'b0, en_seen}, 32'h0);
      check_eq("oob_gnt_cycle", gk, 1);
      check_eq("oob_rvalid_cycle", rk, 2);
      check_eq("oob_err", {31'b0, err_seen}, 32'h1);
      check_eq("oob_rdata", rd_seen, 32'h0);

      // MEM_LAT=3 fetch
      gk = -1; rk = -1; rd_seen = '0; busy_bad = 0;
      @(posedge clock); #1;
      b_if_req = 1'b1; b_if_addr = 32'h8;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (b_if_gnt && gk < 0) begin gk = k; b_if_req = 1'b0; end
         if (b_if_rvalid) begin rk = k; rd_seen = b_if_rdata; end
         if (b_busy != (k >= 1 && k <= 5)) busy_bad++;
      end
      check_eq("lat3_gnt_cycle", gk, 1);
      check_eq("lat3_rvalid_cycle", rk, 5);
      check_eq("lat3_rdata", rd_seen, 32'hCAFEF00D);
      check_eq("lat3_busy_window", busy_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
